rk8e_dma_break: RTL and testbench
=================================

// Module: rk8e_dma_break
// PURPOSE
//  Data-break (DMA) engine downstream of the RK8E SD sector engine: accepts its
//  dmaREQ/dmaRD/dmaWR word requests, obtains a data-break slot from the CPU,
//  runs one 12-bit memory cycle at the 15-bit field+address and returns dmaGNT.
//  Counts words per command and reports late-break errors for status bit 9.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  WAIT cycles before data_late sets (timeout build only)
//  CNT_W           9     width of xfer_count (256-word sector + overflow bit)
// PORTS
//  clk          in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  clear        in   1      sync IOCLR/CAF: abort to IDLE, clear count + flags
//  count_clr    in   1      sync pulse from rk8e on DLDC: xfer_count <= 0
//  dmaREQ       in   1      word request; held high until dmaGNT seen
//  dmaRD        in   1      request is memory->disk (read memory)
//  dmaWR        in   1      request is disk->memory (write memory)
//  dmaADDR      in   15     [0:14] EMA field + 12-bit word address
//  dmaDOUT      in   12     [0:11] word from disk, valid with dmaREQ&dmaWR
//  dmaDIN       out  12     [0:11] word read from memory, valid at dmaGNT
//  dmaGNT       out  1      one-cycle completion pulse
//  break_req    out  1      request data-break slot from CPU
//  break_ok     in   1      CPU at break point; memory owned by this block
//  mem_addr     out  15     memory address
//  mem_wdata    out  12     memory write data
//  mem_we       out  1      one-cycle write strobe
//  mem_re       out  1      one-cycle read strobe; mem_rdata valid next cycle
//  mem_rdata    in   12     memory read data
//  xfer_count   out  CNT_W  words completed since last count_clr/clear
//  proto_err    out  1      sticky: dmaRD and dmaWR both high at accept
//  data_late    out  1      sticky: break not granted within TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; latched addr/data/dir 0.
//  FSM: IDLE -> WAIT -> XFER -> [RDATA] -> GRANT -> RELEASE -> IDLE.
//  IDLE: dmaREQ=1 -> latch dmaADDR, dmaDOUT, dir; go WAIT. If dmaRD==dmaWR
//   (both 1 or both 0): set proto_err (both-1 only), no memory cycle, go GRANT.
//  WAIT: break_req=1; break_ok=1 -> XFER (break_req stays 1 through GRANT).
//  XFER: mem_addr=latched addr; write: mem_we=1, mem_wdata=latched -> GRANT;
//   read: mem_re=1 -> RDATA.
//  RDATA: dmaDIN <= mem_rdata -> GRANT. dmaDIN holds until next read.
//  GRANT: dmaGNT=1 exactly one cycle; xfer_count += 1 (wraps at 2^CNT_W).
//  RELEASE: break_req=0; stay until dmaREQ=0, then IDLE (no double transfer).
//  Latency REQ-sampled to GNT with break_ok already 1: write 3, read 4 cycles.
//  mem_addr/mem_wdata driven only in XFER, else 0; never a strobe outside XFER.
//  count_clr with GRANT same cycle: clear wins, count=0. clear mid-cycle:
//   next cycle IDLE, strobes/GNT/break_req 0, xfer_count, proto_err,
//   data_late 0; a pending dmaREQ restarts from IDLE.
//  break_ok deasserted in XFER/RDATA is ignored (break owned once entered).
// CONFIGURATION
//  RK8E_DMA_TIMEOUT_EN defined: WAIT counter from 0; at TIMEOUT_CYCLES
//   consecutive WAIT cycles set data_late (sticky); FSM keeps waiting, transfer
//   still completes. Counter resets on leaving WAIT.
//  Undefined: no counter; data_late tied 0; TIMEOUT_CYCLES unused.
// TESTING
//  Write: REQ,WR,ADDR=15'o12345,DOUT=12'o7070, break_ok=1 -> mem_we 1 cycle
//   @12345 data 7070, GNT 3 cycles after REQ, xfer_count=1.
//  Read: mem[15'o00200]=12'o1234, REQ,RD -> mem_re 1 cycle, GNT at +4,
//   dmaDIN=1234 at GNT.
//  break_ok low 20 cycles -> break_req high, no strobes; raise -> completes once.
//  REQ held 3 cycles after GNT -> single mem strobe, single count increment.
//  RD=WR=1 -> proto_err=1, GNT pulses, no mem strobe; clear -> proto_err=0.
//  TIMEOUT build, TIMEOUT_CYCLES=8, break_ok low 10 -> data_late=1; 256 writes
//   then count_clr -> xfer_count 256 then 0; reset mid-XFER -> all outputs 0.

Source files
------------

// File: rtl/rk8e_dma_break.sv
// -----------------------------------------------------------------------------
// rk8e_dma_break
//
// Data-break (DMA) engine that sits downstream of the RK8E SD sector engine.
// Each word request (dmaREQ with dmaRD or dmaWR) goes through these steps:
//   1. The block asks the CPU for a data-break slot (break_req).
//   2. Once the CPU is at a break point (break_ok), it runs one 12-bit memory
//      cycle at the 15-bit field+address.
//   3. It returns a one-cycle dmaGNT.
// The block also counts the words completed for each command. It keeps two
// sticky error flags:
//   - proto_err: a request arrived with both directions asserted.
//   - data_late: the break slot was late.
//
// Optional feature (compile-time macro):
//   RK8E_DMA_TIMEOUT_EN  When defined, a WAIT-state watchdog sets data_late
//                        after TIMEOUT_CYCLES consecutive WAIT cycles. The
//                        transfer still completes. When undefined, data_late
//                        is tied low and TIMEOUT_CYCLES is unused.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before data_late sets (timeout build only)
//   CNT_W           width of xfer_count (256-word sector + overflow bit)
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   clear       in   synchronous IOCLR/CAF: abort to IDLE, clear count + flags
//   count_clr   in   synchronous pulse on DLDC: xfer_count <= 0
//   dmaREQ      in   word request, held high until dmaGNT is seen
//   dmaRD       in   request is memory->disk (memory read)
//   dmaWR       in   request is disk->memory (memory write)
//   dmaADDR     in   [14:0] EMA field + 12-bit word address
//   dmaDOUT     in   [11:0] word from disk, valid with dmaREQ & dmaWR
//   dmaDIN      out  [11:0] word read from memory, valid at dmaGNT
//   dmaGNT      out  one-cycle completion pulse
//   break_req   out  data-break slot request to the CPU
//   break_ok    in   CPU at break point; memory owned by this block
//   mem_addr    out  [14:0] memory address (nonzero only in XFER)
//   mem_wdata   out  [11:0] memory write data (nonzero only in XFER)
//   mem_we      out  one-cycle memory write strobe
//   mem_re      out  one-cycle memory read strobe; mem_rdata valid next cycle
//   mem_rdata   in   [11:0] memory read data
//   xfer_count  out  [CNT_W-1:0] words completed since last count_clr/clear
//   proto_err   out  sticky: dmaRD and dmaWR both high at accept
//   data_late   out  sticky: break not granted within TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module rk8e_dma_break #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             count_clr,
   input  logic             dmaREQ,
   input  logic             dmaRD,
   input  logic             dmaWR,
   input  logic [14:0]      dmaADDR,
   input  logic [11:0]      dmaDOUT,
   output logic [11:0]      dmaDIN,
   output logic             dmaGNT,
   output logic             break_req,
   input  logic             break_ok,
   output logic [14:0]      mem_addr,
   output logic [11:0]      mem_wdata,
   output logic             mem_we,
   output logic             mem_re,
   input  logic [11:0]      mem_rdata,
   output logic [CNT_W-1:0] xfer_count,
   output logic             proto_err,
   output logic             data_late
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_XFER,
      S_RDATA,
      S_GRANT,
      S_RELEASE
   } state_t;

   state_t      state;
   state_t      state_nx;

   // Request captured at accept time. The requester may change its inputs
   // once it sees dmaGNT, so the memory cycle must work from these copies.
   logic [14:0] addr_q;
   logic [11:0] data_q;
   logic        wr_q;
   logic        bad_q;     // dmaRD == dmaWR: no memory cycle, no break taken

   logic        accept;
   assign accept = (state == S_IDLE) && dmaREQ && !clear;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking (<=) assignments so that all
   // registers sample the pre-edge values of each other, independent of
   // process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and Moore outputs
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default before the case. A path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      state_nx  = state;
      break_req = 1'b0;
      dmaGNT    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;

      case (state)
         S_IDLE: begin
            if (dmaREQ) begin
               // A request without exactly one direction is acknowledged
               // immediately. Otherwise the requester would hang forever.
               state_nx = (dmaRD == dmaWR) ? S_GRANT : S_WAIT;
            end
         end

         S_WAIT: begin
            break_req = 1'b1;
            if (break_ok) begin
               state_nx = S_XFER;
            end
         end

         // From XFER onward the slot is ours. A late drop of break_ok is
         // deliberately ignored so that a memory cycle is never cut in half.
         S_XFER: begin
            break_req = 1'b1;
            mem_addr  = addr_q;
            if (wr_q) begin
               mem_we    = 1'b1;
               mem_wdata = data_q;
               state_nx  = S_GRANT;
            end else begin
               mem_re   = 1'b1;
               state_nx = S_RDATA;
            end
         end

         S_RDATA: begin
            break_req = 1'b1;
            state_nx  = S_GRANT;
         end

         S_GRANT: begin
            break_req = !bad_q;
            dmaGNT    = 1'b1;
            state_nx  = S_RELEASE;
         end

         // Wait for the requester to drop dmaREQ. A request still held high
         // after dmaGNT is the old request, not a new one.
         S_RELEASE: begin
            if (!dmaREQ) begin
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // clear aborts whatever is in flight. Outputs of the current cycle are
      // left alone; from the next cycle the block is idle.
      if (clear) begin
         state_nx = S_IDLE;
      end
   end

   // ---------------------------------------------------------------------------
   // Request capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
         bad_q  <= 1'b0;
      end else if (accept) begin
         addr_q <= dmaADDR;
         data_q <= dmaDOUT;
         wr_q   <= dmaWR;
         bad_q  <= (dmaRD == dmaWR);
      end
   end

   // ---------------------------------------------------------------------------
   // Read data return: the memory presents data the cycle after mem_re, which
   // is always RDATA. The value holds until the next read.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dmaDIN <= '0;
      end else if (state == S_RDATA) begin
         dmaDIN <= mem_rdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Word counter. A clear in the same cycle as GRANT wins, so the count
   // always restarts from zero for the next command.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xfer_count <= '0;
      end else if (clear || count_clr) begin
         xfer_count <= '0;
      end else if (state == S_GRANT) begin
         xfer_count <= xfer_count + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Protocol error flag: sticky until clear or reset. Only the both-high
   // case is an error. Both-low is treated as an empty request.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if (clear) begin
         proto_err <= 1'b0;
      end else if (accept && dmaRD && dmaWR) begin
         proto_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Late-break watchdog
   // ---------------------------------------------------------------------------
`ifdef RK8E_DMA_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   // Counts consecutive WAIT cycles and saturates at TIMEOUT_CYCLES. It holds
   // zero in every other state, so each new wait starts from 0.
   logic [TW-1:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         data_late <= 1'b0;
      end else if (clear) begin
         wait_cnt  <= '0;
         data_late <= 1'b0;
      end else if (state == S_WAIT) begin
         if (wait_cnt != TW'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + TW'(1);
         end
         // wait_cnt equals N-1 during the N-th consecutive WAIT cycle.
         if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            data_late <= 1'b1;
         end
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   assign data_late = 1'b0;

   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_rk8e_dma_break.sv
// -----------------------------------------------------------------------------
// tb_rk8e_dma_break
//
// Directed bench for rk8e_dma_break with a scoreboard.
//
// Stimulus: each request pushes its expected responses into two queues:
//   - the expected memory strobe (cycle, direction, address, data);
//   - the expected dmaGNT (cycle, read data, count at grant).
// All values are computed by hand from the request.
//
// Monitor: on every falling edge it pops and compares whenever the DUT shows
// a strobe or a grant.
//
// Cycle numbering: cycle 0 is the IDLE cycle in which dmaREQ is first high.
// -----------------------------------------------------------------------------
module tb_rk8e_dma_break;

   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic             count_clr;
   logic             dmaREQ;
   logic             dmaRD;
   logic             dmaWR;
   logic [14:0]      dmaADDR;
   logic [11:0]      dmaDOUT;
   logic [11:0]      dmaDIN;
   logic             dmaGNT;
   logic             break_req;
   logic             break_ok;
   logic [14:0]      mem_addr;
   logic [11:0]      mem_wdata;
   logic             mem_we;
   logic             mem_re;
   logic [11:0]      mem_rdata;
   logic [CNT_W-1:0] xfer_count;
   logic             proto_err;
   logic             data_late;

   rk8e_dma_break #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .count_clr  (count_clr),
      .dmaREQ     (dmaREQ),
      .dmaRD      (dmaRD),
      .dmaWR      (dmaWR),
      .dmaADDR    (dmaADDR),
      .dmaDOUT    (dmaDOUT),
      .dmaDIN     (dmaDIN),
      .dmaGNT     (dmaGNT),
      .break_req  (break_req),
      .break_ok   (break_ok),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .xfer_count (xfer_count),
      .proto_err  (proto_err),
      .data_late  (data_late)
   );

   always #5 clk = ~clk;

   // Simple synchronous memory: read data appears the cycle after mem_re.
   logic [11:0] mem [0:32767];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   typedef struct {
      int               cyc;
      logic             chk_din;
      logic [11:0]      din;
      logic [CNT_W-1:0] cnt;
   } gnt_t;

   typedef struct {
      int          cyc;
      logic        we;
      logic [14:0] addr;
      logic [11:0] wdata;
   } mop_t;

   gnt_t             gnt_q[$];
   mop_t             mop_q[$];
   int               neg_cnt   = 0;
   int               checks    = 0;
   int               failures  = 0;
   logic [CNT_W-1:0] cnt_model = '0;
   logic             exp_late;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Falling-edge index. Every process that reads it at a falling edge sees
   // the same (pre-update) value.
   always @(negedge clk) neg_cnt <= neg_cnt + 1;

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      gnt_t g;
      mop_t m;
      if (!reset) begin
         if (dmaGNT) begin
            if (gnt_q.size() == 0) begin
               check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
               g = gnt_q.pop_front();
               check("gnt_cycle", neg_cnt, g.cyc);
               if (g.chk_din) check("dmaDIN_at_gnt", {20'd0, dmaDIN}, {20'd0, g.din});
               check("count_at_gnt", {23'd0, xfer_count}, {23'd0, g.cnt});
            end
         end
         if (mem_we || mem_re) begin
            if (mop_q.size() == 0) begin
               check("strobe_unexpected", {mem_we, mem_re}, 32'd0);
            end else begin
               m = mop_q.pop_front();
               check("strobe_cycle", neg_cnt, m.cyc);
               check("strobe_kind", {mem_we, mem_re}, {m.we, !m.we});
               check("strobe_addr", {17'd0, mem_addr}, {17'd0, m.addr});
               if (m.we) check("strobe_wdata", {20'd0, mem_wdata}, {20'd0, m.wdata});
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // One request. break_ok rises at falling edge w (0: already high). dmaREQ
   // drops hold cycles after the grant cycle. cclr pulses count_clr in GRANT.
   // ---------------------------------------------------------------------------
   task automatic do_req(input logic rd, input logic wr, input logic [14:0] addr,
                         input logic [11:0] dout, input logic [11:0] exp_din,
                         input int w, input int hold, input logic cclr);
      int   n;
      int   x;
      int   gnt;
      mop_t m;
      gnt_t g;
      @(negedge clk);
      n        = neg_cnt;
      dmaREQ   = 1'b1;
      dmaRD    = rd;
      dmaWR    = wr;
      dmaADDR  = addr;
      dmaDOUT  = dout;
      break_ok = (w == 0);
      x        = ((w < 1) ? 1 : w) + 1;          // XFER cycle
      if (rd == wr) begin
         gnt = n + 1;
      end else begin
         m.cyc = n + x; m.we = wr; m.addr = addr; m.wdata = dout;
         mop_q.push_back(m);
         gnt = n + x + (wr ? 1 : 2);
      end
      g.cyc = gnt; g.chk_din = rd && !wr; g.din = exp_din; g.cnt = cnt_model;
      gnt_q.push_back(g);
      cnt_model = cclr ? '0 : cnt_model + 1'b1;
      for (int i = n + 1; i <= gnt + hold + 2; i++) begin
         @(negedge clk);
         if (w > 0 && i == n + w) begin
            check("break_req_in_wait", {31'd0, break_req}, 32'd1);
            break_ok = 1'b1;
         end
         count_clr = cclr && (i == gnt);
         if (i == gnt + hold) dmaREQ = 1'b0;
      end
      count_clr = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear     = 1'b0;
      cnt_model = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int   n;
      mop_t m;
      gnt_t g;
`ifdef RK8E_DMA_TIMEOUT_EN
      exp_late = 1'b1;
`else
      exp_late = 1'b0;
`endif
      reset = 1'b1; clear = 1'b0; count_clr = 1'b0; dmaREQ = 1'b0;
      dmaRD = 1'b0; dmaWR = 1'b0; dmaADDR = '0; dmaDOUT = '0; break_ok = 1'b1;
      #1;
      check("reset_strobes_gnt_req", {dmaGNT, break_req, mem_we, mem_re}, 32'd0);
      check("reset_flags", {proto_err, data_late}, 32'd0);
      check("reset_count_din", {xfer_count, dmaDIN}, 32'd0);
      check("reset_mem_bus", {mem_addr, mem_wdata}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Basic write, then write/read pairs.
      do_req(1'b0, 1'b1, 15'o12345, 12'o7070, 12'o0000, 0, 0, 1'b0);
      check("count_after_write", {23'd0, xfer_count}, 32'd1);
      do_req(1'b0, 1'b1, 15'o00200, 12'o1234, 12'o0000, 0, 0, 1'b0);
      do_req(1'b1, 1'b0, 15'o00200, 12'o0000, 12'o1234, 0, 0, 1'b0);
      do_req(1'b1, 1'b0, 15'o12345, 12'o0000, 12'o7070, 0, 0, 1'b0);
      check("din_holds", {20'd0, dmaDIN}, {20'd0, 12'o7070});
      check("mem_bus_idle", {mem_addr, mem_wdata}, 32'd0);

      // Slow break grant, then a request held past its grant.
      do_req(1'b0, 1'b1, 15'o00300, 12'o5555, 12'o0000, 20, 0, 1'b0);
      do_req(1'b0, 1'b1, 15'o00301, 12'o0001, 12'o0000, 0, 3, 1'b0);
      check("count_after_six", {23'd0, xfer_count}, 32'd6);

      // Protocol errors.
      do_req(1'b1, 1'b1, 15'o00000, 12'o0000, 12'o0000, 0, 0, 1'b0);
      check("proto_err_set", {31'd0, proto_err}, 32'd1);
      pulse_clear();
      check("proto_err_cleared", {31'd0, proto_err}, 32'd0);
      check("count_cleared", {23'd0, xfer_count}, 32'd0);
      do_req(1'b0, 1'b0, 15'o00000, 12'o0000, 12'o0000, 0, 0, 1'b0);
      check("no_proto_err_both_low", {31'd0, proto_err}, 32'd0);

      // count_clr in the GRANT cycle wins over the increment.
      do_req(1'b0, 1'b1, 15'o00302, 12'o0002, 12'o0000, 0, 0, 1'b1);
      check("count_clr_wins", {23'd0, xfer_count}, 32'd0);

      // Late break: 10 WAIT cycles against a threshold of 8.
      do_req(1'b0, 1'b1, 15'o00303, 12'o0003, 12'o0000, 10, 0, 1'b0);
      check("data_late", {31'd0, data_late}, {31'd0, exp_late});
      pulse_clear();
      check("data_late_cleared", {31'd0, data_late}, 32'd0);

      // clear during WAIT while dmaREQ stays high: restart from IDLE.
      @(negedge clk);
      n = neg_cnt;
      dmaREQ = 1'b1; dmaRD = 1'b0; dmaWR = 1'b1;
      dmaADDR = 15'o00400; dmaDOUT = 12'o4321; break_ok = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_drops_break_req", {31'd0, break_req}, 32'd0);
      break_ok = 1'b1;
      m.cyc = n + 5; m.we = 1'b1; m.addr = 15'o00400; m.wdata = 12'o4321;
      mop_q.push_back(m);
      g.cyc = n + 6; g.chk_din = 1'b0; g.din = '0; g.cnt = '0;
      gnt_q.push_back(g);
      cnt_model = 1;
      repeat (3) @(negedge clk);
      dmaREQ = 1'b0;
      repeat (2) @(negedge clk);
      check("count_after_restart", {23'd0, xfer_count}, 32'd1);

      // A full 256-word sector, then count_clr.
      pulse_clear();
      for (int i = 0; i < 256; i++) begin
         do_req(1'b0, 1'b1, 15'(i), 12'(i * 3), 12'o0000, 0, 0, 1'b0);
      end
      check("count_256", {23'd0, xfer_count}, 32'd256);
      @(negedge clk);
      count_clr = 1'b1;
      @(negedge clk);
      count_clr = 1'b0;
      check("count_clr_after_256", {23'd0, xfer_count}, 32'd0);
      cnt_model = '0;

      // Reset in the middle of the XFER cycle.
      do_req(1'b0, 1'b1, 15'o00500, 12'o0505, 12'o0000, 0, 0, 1'b0);
      do_req(1'b1, 1'b0, 15'o00500, 12'o0000, 12'o0505, 0, 0, 1'b0);
      @(negedge clk);
      n = neg_cnt;
      dmaREQ = 1'b1; dmaRD = 1'b0; dmaWR = 1'b1;
      dmaADDR = 15'o00501; dmaDOUT = 12'o0707; break_ok = 1'b1;
      m.cyc = n + 2; m.we = 1'b1; m.addr = 15'o00501; m.wdata = 12'o0707;
      mop_q.push_back(m);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_xfer_strobes_gnt_req", {dmaGNT, break_req, mem_we, mem_re}, 32'd0);
      check("rst_xfer_count_din", {xfer_count, dmaDIN}, 32'd0);
      check("rst_xfer_mem_bus", {mem_addr, mem_wdata}, 32'd0);
      check("rst_xfer_flags", {proto_err, data_late}, 32'd0);
      dmaREQ = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      check("gnt_queue_drained", gnt_q.size(), 32'd0);
      check("strobe_queue_drained", mop_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
